splitmix64_sched: RTL and testbench

- Shared SplitMix64 random-number service for up to N_REQ requesters.
- Holds the generator state and arbitrates requesters round-robin, one 64-bit word per grant.
- Runs a 2-stage mixing pipeline and returns each word tagged with the requester ID over a valid/ready response port.
- Sits between the splitmix64 datapath and the consumers (scramblers, test-pattern units) that previously each needed a private generator.

---
 rtl/splitmix64_sched.sv | 111 +++++++++++
 tb/tb_splitmix64_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/splitmix64_sched.sv
// Shared SplitMix64 generator: round-robin arbitration over N_REQ requesters,
// two-stage mixing pipeline, tagged words returned over a valid/ready port.
module splitmix64_sched #(
    parameter int          N_REQ        = 4,
    parameter int          ID_W         = $clog2(N_REQ),
    parameter logic [63:0] SEED_DEFAULT = 64'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [63:0]      seed_in,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic [ID_W-1:0]  rsp_id,
    output logic             busy,
    output logic [31:0]      issued_count
);
    localparam logic [63:0]     GAMMA   = 64'h9E3779B97F4A7C15;
    localparam logic [63:0]     C1      = 64'hBF58476D1CE4E5B9;
    localparam logic [63:0]     C2      = 64'h94D049BB133111EB;
    localparam logic [ID_W-1:0] RR_INIT = ID_W'(N_REQ - 1);

    logic [63:0]     state, s1, s2;
    logic [ID_W-1:0] s1_id, s2_id, rr_ptr;
    logic            s1_v, s2_v;

    logic            stall, grant_en, grant_any, issue;
    logic [ID_W-1:0] grant_id;
    logic [63:0]     ns, s1_next, s2_next;

    assign stall    = s2_v & ~rsp_ready;
    // Gating with rst_n makes req_ready drop the instant reset asserts.
    assign grant_en = rst_n & ~stall & ~seed_load;
    assign issue    = grant_en & grant_any;

    // Round-robin pick: the lowest valid index above rr_ptr wins; if none,
    // wrap around to the lowest valid index overall.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        grant_any = 1'b0;
        grant_id  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) > rr_ptr)) begin
                grant_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready = N_REQ'(1) << grant_id;
        end
    end

    assign ns      = state + GAMMA;
    assign s1_next = (ns ^ (ns >> 30)) * C1;
    assign s2_next = (s1 ^ (s1 >> 27)) * C2;

    // NOTE: all state uses non-blocking assignment so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SEED_DEFAULT;
            s1           <= '0;
            s1_id        <= '0;
            s1_v         <= 1'b0;
            s2           <= '0;
            s2_id        <= '0;
            s2_v         <= 1'b0;
            rr_ptr       <= RR_INIT;
            issued_count <= '0;
        end else begin
            if (seed_load) begin
                state <= seed_in;
            end else if (issue) begin
                state        <= ns;
                rr_ptr       <= grant_id;
                issued_count <= issued_count + 32'd1;
            end

            if (!stall) begin
                s1_v <= issue;
                if (issue) begin
                    s1    <= s1_next;
                    s1_id <= grant_id;
                end
                s2_v <= s1_v;
                if (s1_v) begin
                    s2    <= s2_next;
                    s2_id <= s1_id;
                end
            end
        end
    end

    assign rsp_data  = s2 ^ (s2 >> 31);
    assign rsp_id    = s2_id;
    assign rsp_valid = s2_v;
    assign busy      = s1_v | s2_v;

endmodule

// File: tb/tb_splitmix64_sched.sv
// Scoreboard bench for splitmix64_sched: grants push expected words, a
// response monitor pops and compares; directed checks cover latency/reseed/reset.
module tb_splitmix64_sched;
    localparam int          N_REQ = 4;
    localparam int          ID_W  = $clog2(N_REQ);
    localparam logic [63:0] GAMMA = 64'h9E3779B97F4A7C15;
    localparam logic [63:0] C1    = 64'hBF58476D1CE4E5B9;
    localparam logic [63:0] C2    = 64'h94D049BB133111EB;
    localparam logic [63:0] W0    = 64'hE220A8397B1DCDAF;
    localparam logic [63:0] W1    = 64'h6E789E6AA1B965F4;
    localparam logic [63:0] W2    = 64'h06C45D188009454F;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             seed_load = 1'b0;
    logic [63:0]      seed_in   = '0;
    logic [N_REQ-1:0] req_valid = '0;
    logic [N_REQ-1:0] req_ready;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [63:0]      rsp_data;
    logic [ID_W-1:0]  rsp_id;
    logic             busy;
    logic [31:0]      issued_count;

    typedef struct packed {
        logic [63:0]     data;
        logic [ID_W-1:0] id;
    } exp_t;

    exp_t        exp_q[$];
    int          n_total     = 0;
    int          n_bad       = 0;
    int          n_grants    = 0;
    logic [63:0] model_state = 64'h0;

    logic [N_REQ-1:0] grant_seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    splitmix64_sched #(
        .N_REQ       (N_REQ),
        .ID_W        (ID_W),
        .SEED_DEFAULT(64'h0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seed_load   (seed_load),
        .seed_in     (seed_in),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .busy        (busy),
        .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] sm_mix(input logic [63:0] x);
        logic [63:0] z;
        z = (x ^ (x >> 30)) * C1;
        z = (z ^ (z >> 27)) * C2;
        return z ^ (z >> 31);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant side of the scoreboard: every observed transfer advances the
    // reference generator and queues the word it must produce.
    always @(negedge clk) begin
        if (rst_n) begin
            if (seed_load) model_state = seed_in;
            if (req_ready != '0) begin
                check("grant_onehot", 64'($onehot(req_ready & req_valid)), 64'd1);
                for (int i = 0; i < N_REQ; i++) begin
                    if (req_ready[i]) begin
                        exp_t e;
                        model_state = model_state + GAMMA;
                        e.data = sm_mix(model_state);
                        e.id   = ID_W'(i);
                        exp_q.push_back(e);
                        n_grants++;
                    end
                end
            end
        end
    end

    logic            hold_prev = 1'b0;
    logic [63:0]     data_prev = '0;
    logic [ID_W-1:0] id_prev   = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_prev) begin
                check("hold_valid", 64'(rsp_valid), 64'd1);
                check("hold_data", rsp_data, data_prev);
                check("hold_id", 64'(rsp_id), 64'(id_prev));
            end
            if (rsp_valid && !rsp_ready) check("stall_req_ready", 64'(req_ready), 64'd0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got %h want none", rsp_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                end
            end
            hold_prev = rsp_valid && !rsp_ready;
            data_prev = rsp_data;
            id_prev   = rsp_id;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_issued", 64'(issued_count), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Seed-0 stream from requester 0, latency 2.
        req_valid = 4'b0001;
        #1 check("t1_req_ready", 64'(req_ready), 64'b0001);
        check("t1_valid_c0", 64'(rsp_valid), 64'd0);
        tick();
        check("t1_valid_c1", 64'(rsp_valid), 64'd0);
        tick();
        check("t1_valid_c2", 64'(rsp_valid), 64'd1);
        check("t1_w0", rsp_data, W0);
        check("t1_id0", 64'(rsp_id), 64'd0);
        tick();
        req_valid = '0;
        check("t1_w1", rsp_data, W1);
        check("t1_issued", 64'(issued_count), 64'd3);
        tick();
        check("t1_w2", rsp_data, W2);
        tick();

        // Sparse requests: each granted at once; pointer moves 2 then 1.
        req_valid = 4'b0100;
        #1 check("sp_req2", 64'(req_ready), 64'b0100);
        tick();
        req_valid = 4'b0010;
        #1 check("sp_req1", 64'(req_ready), 64'b0010);
        tick();
        req_valid = 4'b1111;
        #1 check("sp_after_ptr1", 64'(req_ready), 64'b0100);
        tick();
        req_valid = 4'b1000;
        #1 check("sp_req3", 64'(req_ready), 64'b1000);
        tick();

        // All four continuously: strict rotation from requester 0.
        for (int k = 0; k < 6; k++) begin
            req_valid = 4'b1111;
            #1 check($sformatf("rr_grant%0d", k), 64'(req_ready), 64'(grant_seq[k]));
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // Backpressure with both stages full.
        req_valid = 4'b1111;
        tick();
        tick();
        rsp_ready = 1'b0;
        #1 check("bp_valid", 64'(rsp_valid), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_req_ready%0d", k), 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Reseed after five words: no grant in the load cycle.
        req_valid = 4'b0001;
        repeat (5) tick();
        seed_load = 1'b1;
        seed_in   = 64'h0;
        #1 check("rs_no_grant", 64'(req_ready), 64'd0);
        tick();
        seed_load = 1'b0;
        tick();
        req_valid = '0;
        check("rs_bubble", 64'(rsp_valid), 64'd0);
        tick();
        check("rs_valid", 64'(rsp_valid), 64'd1);
        check("rs_first_word", rsp_data, W0);
        repeat (3) tick();

        // Reseed while stalled still loads the state.
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        rsp_ready = 1'b0;
        seed_load = 1'b1;
        seed_in   = 64'h0;
        #1 check("rss_no_grant", 64'(req_ready), 64'd0);
        tick();
        seed_load = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        check("rss_first_word", rsp_data, W0);
        repeat (3) tick();

        // Async reset with both stages valid.
        req_valid = 4'b0001;
        tick();
        tick();
        #2 rst_n = 1'b0;
        exp_q.delete();
        model_state = 64'h0;
        n_grants    = 0;
        #1 check("ar_rsp_valid", 64'(rsp_valid), 64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_req_ready", 64'(req_ready), 64'd0);
        check("ar_issued", 64'(issued_count), 64'd0);
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_idle", 64'(rsp_valid), 64'd0);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        check("ar_issued1", 64'(issued_count), 64'd1);
        tick();
        check("ar_valid", 64'(rsp_valid), 64'd1);
        check("ar_first_word", rsp_data, W0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        tick();
        check("end_queue_drained", 64'(exp_q.size()), 64'd0);
        check("end_busy", 64'(busy), 64'd0);
        check("end_issued", 64'(issued_count), 64'(n_grants));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
